// File: rtl/key_load_sched_pkg.sv
// key_load_sched_pkg: shared types and helpers for the key-expansion scheduler
package key_load_sched_pkg;
  typedef logic ulogic1;
  typedef logic [1:0] ulogic2;
  typedef logic [255:0] ulogic256;
  typedef enum logic [1:0] {KEY128 = 2'b00, KEY192 = 2'b01, KEY256 = 2'b10} key_mode_t;
  localparam ulogic2 KEY_ILLEGAL = 2'b11;
  typedef enum logic [2:0] {IDLE, START, WAIT_LOW, WAIT_HIGH, DONE, ERR} ksched_state_t;
  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 == n) ? 0 : i + 1;
  endfunction
endpackage

// File: rtl/key_load_sched_arb.sv
// rr_arbiter_onehot: round-robin pick starting at ptr_i, one-hot grant plus index
module rr_arbiter_onehot #(
  parameter int N = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW-1:0] js;
  assign any_o = |req_i;
  // scan farthest-first so the requester closest to the pointer wins last
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    js = '0;
    for (int k = N - 1; k >= 0; k--) begin
      js = IW'((int'(ptr_i) + k) % N);
      if (req_i[js]) begin
        gnt_o = '0;
        gnt_o[js] = 1'b1;
        idx_o = js;
      end
    end
  end
endmodule

// File: rtl/key_load_sched.sv
// key_load_sched: round-robin sharing of one AES key-expansion port, with loaded-key reuse
module key_load_sched
  import key_load_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TIMEOUT = 64,
  localparam int IDXW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              resetL,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*256-1:0] req_key,
  input  logic [NREQ*2-1:0] req_mode,
  output logic [NREQ-1:0]   done,
  output logic              hit,
  output logic [NREQ-1:0]   err,
  output logic              busy,
  output logic [IDXW-1:0]   owner,
  output logic              owner_valid,
  output logic              key_start,
  output logic [1:0]        key_mode,
  output logic [255:0]      key,
  input  logic              key_ready
);
  localparam int CNTW = $clog2(TIMEOUT) + 1;
  ksched_state_t state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d, win_q, win_d, owner_q, owner_d, gnt_idx;
  logic [NREQ-1:0] gnt, done_q, err_q;
  logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
  ulogic256 key_q, key_d, win_key;
  ulogic2 mode_q, mode_d, win_mode;
  logic ov_q, ov_d, hit_q, hit_d, start_q, busy_q, any_req, cache_hit, tmo;

  rr_arbiter_onehot #(.N(NREQ), .IW(IDXW)) u_arb (
    .req_i(req),
    .ptr_i(ptr_q),
    .gnt_o(gnt),
    .idx_o(gnt_idx),
    .any_o(any_req)
  );

  always_comb begin
    win_key = '0;
    win_mode = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_key |= {256{gnt[i]}} & req_key[256*i +: 256];
      win_mode |= {2{gnt[i]}} & req_mode[2*i +: 2];
    end
  end

  assign cache_hit = ov_q && key_ready && win_key == key_q && win_mode == mode_q;
  assign cnt_inc = cnt_q + 1'b1;
  assign tmo = cnt_inc == CNTW'(TIMEOUT - 1);

  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    win_d = win_q;
    cnt_d = cnt_q;
    key_d = key_q;
    mode_d = mode_q;
    owner_d = owner_q;
    ov_d = ov_q;
    hit_d = 1'b0;
    case (state_q)
      IDLE: if (any_req) begin
        win_d = gnt_idx;
        if (win_mode == KEY_ILLEGAL) state_d = ERR;
        else if (cache_hit) begin
          state_d = DONE;
          hit_d = 1'b1;
        end else begin
          key_d = win_key;
          mode_d = win_mode;
          ov_d = 1'b0;
          state_d = START;
        end
      end
      START: begin
        cnt_d = '0;
        state_d = WAIT_LOW;
      end
      WAIT_LOW, WAIT_HIGH: begin
        cnt_d = cnt_inc;
        if (state_q == WAIT_LOW && !key_ready) state_d = WAIT_HIGH;
        else if (state_q == WAIT_HIGH && key_ready) begin
          state_d = DONE;
          owner_d = win_q;
          ov_d = 1'b1;
        end else if (tmo) state_d = ERR;
      end
      default: begin
        ptr_d = IDXW'(wrap_inc(int'(win_q), NREQ));
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetL) begin
      state_q <= IDLE;
      ptr_q <= '0;
      win_q <= '0;
      cnt_q <= '0;
      key_q <= '0;
      mode_q <= '0;
      owner_q <= '0;
      ov_q <= 1'b0;
      hit_q <= 1'b0;
      done_q <= '0;
      err_q <= '0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      win_q <= win_d;
      cnt_q <= cnt_d;
      key_q <= key_d;
      mode_q <= mode_d;
      owner_q <= owner_d;
      ov_q <= ov_d;
      hit_q <= hit_d;
      done_q <= (state_d == DONE) ? NREQ'(1) << win_d : '0;
      err_q <= (state_d == ERR) ? NREQ'(1) << win_d : '0;
      start_q <= state_d == START;
      busy_q <= state_d != IDLE;
    end
  end

  assign done = done_q;
  assign err = err_q;
  assign hit = hit_q;
  assign busy = busy_q;
  assign owner = owner_q;
  assign owner_valid = ov_q;
  assign key_start = start_q;
  assign key_mode = mode_q;
  assign key = key_q;
endmodule

// File: tb/tb_key_load_sched.sv
// tb_key_load_sched: directed scoreboard bench for key_load_sched with a simple AES core model
module tb_key_load_sched;
  localparam logic [255:0] KA = {32{8'hA5}};
  localparam logic [255:0] K0A = {8{32'h1111_0000}};
  localparam logic [255:0] K0B = {8{32'h2222_0000}};
  localparam logic [255:0] K1A = {8{32'h3333_1111}};
  localparam logic [255:0] K1B = {8{32'h4444_1111}};
  localparam logic [255:0] KT = {8{32'hDEAD_BEEF}};
  localparam logic [255:0] KR = {8{32'h0BAD_F00D}};

  logic clk, resetL, hit, busy, owner_valid, key_start, key_ready;
  logic [1:0] req, done, err, key_mode;
  logic [0:0] owner;
  logic [511:0] req_key;
  logic [3:0] req_mode;
  logic [255:0] key;

  key_load_sched #(.NREQ(2), .TIMEOUT(64)) dut (
    .clk(clk), .resetL(resetL), .req(req), .req_key(req_key), .req_mode(req_mode),
    .done(done), .hit(hit), .err(err), .busy(busy), .owner(owner),
    .owner_valid(owner_valid), .key_start(key_start), .key_mode(key_mode),
    .key(key), .key_ready(key_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] onehot;
    bit is_err;
    bit hit;
    logic [255:0] key;
    logic [1:0] mode;
    bit chk_owner;
    logic owner;
    logic ov;
  } exp_t;
  exp_t sb[$];
  logic [257:0] jq0[$];
  logic [257:0] jq1[$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, ks_cnt = 0, start_cyc = 0, err_cyc = 0, pulses = 0;
  bit rand_rst = 1'b0;
  int drop_dly = 1, rise_dly = 10;
  bit never_rise = 1'b0;
  int cm_cnt;
  bit cm_act;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AES core model: drops ready drop_dly cycles after start, raises it rise_dly later
  always @(posedge clk) begin
    if (!resetL) begin
      key_ready <= 1'b1;
      cm_act <= 1'b0;
      cm_cnt <= 0;
    end else if (key_start) begin
      cm_act <= 1'b1;
      cm_cnt <= 0;
    end else if (cm_act) begin
      cm_cnt <= cm_cnt + 1;
      if (cm_cnt + 1 == drop_dly) key_ready <= 1'b0;
      if (cm_cnt + 1 == drop_dly + rise_dly && !never_rise) begin
        key_ready <= 1'b1;
        cm_act <= 1'b0;
      end
    end
  end

  // requesters: hold req while a job is queued, advance on own done/err
  always @(negedge clk) begin
    if (!resetL) begin
      req = rand_rst ? 2'($urandom) : 2'b00;
      req_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      req_mode = 4'($urandom);
      jq0.delete();
      jq1.delete();
    end else begin
      if (done[0] || err[0]) jq0.delete(0);
      if (done[1] || err[1]) jq1.delete(0);
      req[0] = jq0.size() != 0;
      req[1] = jq1.size() != 0;
      if (req[0]) {req_mode[1:0], req_key[255:0]} = jq0[0];
      if (req[1]) {req_mode[3:2], req_key[511:256]} = jq1[0];
    end
  end

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (key_start) begin
      ks_cnt++;
      start_cyc = cyc;
    end
    if (|done || |err) begin
      pulses++;
      if (|err) err_cyc = cyc;
      check("pulse_expected", 256'(sb.size() != 0), 256'(1));
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("kind", 256'({|done, |err}), 256'(e.is_err ? 2'b01 : 2'b10));
        check("grant", 256'(e.is_err ? err : done), 256'(e.onehot));
        check("hit", 256'(hit), 256'(e.hit));
        check("owner_valid", 256'(owner_valid), 256'(e.ov));
        if (e.chk_owner) check("owner", 256'(owner), 256'(e.owner));
        check("key", key, e.key);
        check("key_mode", 256'(key_mode), 256'(e.mode));
      end
    end
  end

  task automatic issue(input int r, input logic [255:0] k, input logic [1:0] m, input bit is_err,
                       input bit h, input logic [255:0] ek, input logic [1:0] em,
                       input bit co, input logic eo, input logic eov);
    exp_t e;
    @(posedge clk);
    #2;
    e.onehot = 2'b01 << r;
    e.is_err = is_err;
    e.hit = h;
    e.key = ek;
    e.mode = em;
    e.chk_owner = co;
    e.owner = eo;
    e.ov = eov;
    sb.push_back(e);
    if (r == 0) jq0.push_back({m, k});
    else jq1.push_back({m, k});
  endtask

  task automatic drain(input string tag, input int max);
    for (int i = 0; i < max && sb.size() != 0; i++) @(negedge clk);
    check(tag, 256'(sb.size()), 256'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ks0, p0;
    resetL = 1'b0;
    rand_rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    resetL = 1'b1;
    rand_rst = 1'b0;
    @(negedge clk);
    check("rst_done", 256'(done), 256'(0));
    check("rst_err", 256'(err), 256'(0));
    check("rst_hit", 256'(hit), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_owner", 256'(owner), 256'(0));
    check("rst_owner_valid", 256'(owner_valid), 256'(0));
    check("rst_key_start", 256'(key_start), 256'(0));
    check("rst_key_mode", 256'(key_mode), 256'(0));
    check("rst_key", key, 256'(0));
    check("rst_no_start", 256'(ks_cnt), 256'(0));

    ks0 = ks_cnt;
    issue(0, KA, 2'b10, 0, 0, KA, 2'b10, 1, 1'b0, 1'b1);
    drain("miss_drain", 200);
    check("miss_starts", 256'(ks_cnt - ks0), 256'(1));

    ks0 = ks_cnt;
    issue(0, KA, 2'b10, 0, 1, KA, 2'b10, 1, 1'b0, 1'b1);
    drain("hit_drain", 200);
    check("hit_starts", 256'(ks_cnt - ks0), 256'(0));

    ks0 = ks_cnt;
    issue(0, KA, 2'b01, 0, 0, KA, 2'b01, 1, 1'b0, 1'b1);
    drain("mode01_drain", 200);
    check("mode01_starts", 256'(ks_cnt - ks0), 256'(1));

    ks0 = ks_cnt;
    issue(1, K1A, 2'b11, 1, 0, KA, 2'b01, 1, 1'b0, 1'b1);
    drain("illegal_drain", 200);
    check("illegal_starts", 256'(ks_cnt - ks0), 256'(0));

    ks0 = ks_cnt;
    issue(0, K0A, 2'b00, 0, 0, K0A, 2'b00, 1, 1'b0, 1'b1);
    issue(1, K1A, 2'b01, 0, 0, K1A, 2'b01, 1, 1'b1, 1'b1);
    issue(0, K0B, 2'b10, 0, 0, K0B, 2'b10, 1, 1'b0, 1'b1);
    issue(1, K1B, 2'b10, 0, 0, K1B, 2'b10, 1, 1'b1, 1'b1);
    drain("contention_drain", 400);
    check("contention_starts", 256'(ks_cnt - ks0), 256'(4));

    never_rise = 1'b1;
    ks0 = ks_cnt;
    issue(0, KT, 2'b00, 1, 0, KT, 2'b00, 0, 1'b0, 1'b0);
    drain("timeout_drain", 300);
    check("timeout_starts", 256'(ks_cnt - ks0), 256'(1));
    check("timeout_latency", 256'(err_cyc - start_cyc), 256'(64));

    never_rise = 1'b0;
    rise_dly = 30;
    @(posedge clk);
    #2;
    jq1.push_back({2'b10, KR});
    repeat (8) @(negedge clk);
    check("midop_busy", 256'(busy), 256'(1));
    p0 = pulses;
    @(posedge clk);
    #2;
    resetL = 1'b0;
    @(posedge clk);
    #2;
    resetL = 1'b1;
    @(negedge clk);
    check("midop_busy_cleared", 256'(busy), 256'(0));
    check("midop_key_cleared", key, 256'(0));
    check("midop_owner_valid", 256'(owner_valid), 256'(0));
    repeat (40) @(negedge clk);
    check("midop_no_pulse", 256'(pulses - p0), 256'(0));

    rise_dly = 10;
    ks0 = ks_cnt;
    issue(0, KA, 2'b10, 0, 0, KA, 2'b10, 1, 1'b0, 1'b1);
    drain("recover_drain", 200);
    check("recover_starts", 256'(ks_cnt - ks0), 256'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
